// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count, status flags and
// combinational overflow/underflow indication on the offending access cycle.
module sync_fifo #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_wr,
    input  logic                  i_rd,
    output logic [ADDR_WIDTH-1:0] o_count,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_half_full,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int unsigned SLOTS = 1 << ADDR_WIDTH;
    localparam int unsigned DEPTH = SLOTS - 1;
    localparam int unsigned HALF  = 1 << (ADDR_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [SLOTS];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_wr_en;
    logic w_rd_en;

    // Status decoded from the registered count, so flags move on the edge after an access.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == ADDR_WIDTH'(DEPTH));

    // A simultaneous pop frees a slot, so a write on a full FIFO still lands.
    assign w_wr_en = i_rst && i_wr && (!w_full || i_rd);
    assign w_rd_en = i_rst && i_rd && !w_empty;

    assign o_data      = r_mem[r_rd_ptr];
    assign o_count     = r_count;
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_half_full = (r_count >= ADDR_WIDTH'(HALF));
    assign o_overflow  = i_rst && i_wr && w_full && !i_rd;
    assign o_underflow = i_rst && i_rd && w_empty;

    // Storage is left uninitialised by reset; only the pointers and count are cleared.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + ADDR_WIDTH'(1);
                2'b01:   r_count <= r_count - ADDR_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (ADDR_WIDTH=3, DATA_WIDTH=8, capacity 7).
module tb_sync_fifo;

    logic       clk;
    logic       i_rst;
    logic [7:0] i_data;
    logic [7:0] o_data;
    logic       i_wr;
    logic       i_rd;
    logic [2:0] o_count;
    logic       o_empty;
    logic       o_full;
    logic       o_half_full;
    logic       o_overflow;
    logic       o_underflow;

    int total = 0;
    int bad   = 0;

    sync_fifo #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_data      (i_data),
        .o_data      (o_data),
        .i_wr        (i_wr),
        .i_rd        (i_rd),
        .o_count     (o_count),
        .o_empty     (o_empty),
        .o_full      (o_full),
        .o_half_full (o_half_full),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Flags follow from the expected count after the edge.
    task automatic check_state(input string tag, input logic [2:0] exp_cnt);
        check({tag, ".count"}, 32'(o_count), 32'(exp_cnt));
        check({tag, ".empty"}, 32'(o_empty), 32'(exp_cnt == 3'd0));
        check({tag, ".full"},  32'(o_full),  32'(exp_cnt == 3'd7));
        check({tag, ".half"},  32'(o_half_full), 32'(exp_cnt >= 3'd4));
    endtask

    // Drive one cycle: check combinational outputs before the edge, registered state after.
    task automatic step(input string tag, input logic wr, input logic rd, input logic [7:0] din,
                        input logic exp_ovf, input logic exp_unf,
                        input logic chk_data, input logic [7:0] exp_data,
                        input logic [2:0] exp_cnt);
        @(negedge clk);
        i_wr   = wr;
        i_rd   = rd;
        i_data = din;
        #1;
        check({tag, ".ovf"}, 32'(o_overflow), 32'(exp_ovf));
        check({tag, ".unf"}, 32'(o_underflow), 32'(exp_unf));
        if (chk_data) check({tag, ".data"}, 32'(o_data), 32'(exp_data));
        @(posedge clk);
        #1;
        check_state(tag, exp_cnt);
    endtask

    initial begin
        logic [7:0] d;
        i_rst  = 1'b0;
        i_wr   = 1'b0;
        i_rd   = 1'b1;
        i_data = 8'h00;

        // Reset held 5 cycles with a read pending: no underflow while in reset.
        repeat (5) begin
            @(negedge clk);
            check("rst.unf", 32'(o_underflow), 32'd0);
            check("rst.ovf", 32'(o_overflow), 32'd0);
        end
        i_rst = 1'b1;
        i_rd  = 1'b0;
        #1;
        check_state("rst", 3'd0);
        check("rst.unf_off", 32'(o_underflow), 32'd0);

        // Write 1..5, then pop in order.
        for (int i = 1; i <= 5; i++)
            step("wr5", 1'b1, 1'b0, 8'(i), 1'b0, 1'b0, (i > 1), 8'h01, 3'(i));
        for (int i = 1; i <= 5; i++)
            step("rd5", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'(i), 3'(5 - i));

        // Fill with 10 writes: 7 accepted, last 3 overflow.
        for (int i = 0; i < 10; i++)
            step("fill", 1'b1, 1'b0, 8'(8'h10 + i), (i >= 7), 1'b0, (i > 0), 8'h10,
                 (i >= 7) ? 3'd7 : 3'(i + 1));

        // Drain 10: 7 words in order, then 3 underflows.
        for (int i = 0; i < 10; i++)
            step("drain", 1'b0, 1'b1, 8'h00, 1'b0, (i >= 7), (i < 7), 8'(8'h10 + i),
                 (i >= 7) ? 3'd0 : 3'(6 - i));

        // rd+wr on empty: first cycle underflows, later cycles pass data one behind.
        for (int i = 0; i < 10; i++)
            step("rdwr_empty", 1'b1, 1'b1, 8'(8'h20 + i), 1'b0, (i == 0), (i > 0),
                 8'(8'h20 + i - 1), 3'd1);
        for (int i = 0; i < 6; i++)
            step("refill", 1'b1, 1'b0, 8'(8'h30 + i), 1'b0, 1'b0, 1'b1, 8'h29, 3'(i + 2));

        // Full with rd+wr: queue is 29,30..35 then 40.. as written.
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      d = 8'h29;
            else if (i <= 6) d = 8'(8'h30 + i - 1);
            else             d = 8'(8'h40 + i - 7);
            step("full_rdwr", 1'b1, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b1, d, 3'd7);
        end
        for (int i = 0; i < 7; i++)
            step("final_drain", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'(8'h43 + i), 3'(6 - i));

        // Mid-operation reset: reset beats a concurrent write, pointers restart.
        for (int i = 0; i < 3; i++)
            step("pre_rst", 1'b1, 1'b0, 8'(8'h50 + i), 1'b0, 1'b0, (i > 0), 8'h50, 3'(i + 1));
        @(negedge clk);
        i_rst  = 1'b0;
        i_wr   = 1'b1;
        i_rd   = 1'b1;
        i_data = 8'h5f;
        #1;
        check("mid_rst.ovf", 32'(o_overflow), 32'd0);
        check("mid_rst.unf", 32'(o_underflow), 32'd0);
        @(posedge clk);
        #1;
        check_state("mid_rst", 3'd0);
        @(negedge clk);
        i_rst = 1'b1;
        i_wr  = 1'b0;
        i_rd  = 1'b0;
        step("post_rst_wr", 1'b1, 1'b0, 8'h60, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1);
        step("post_rst_rd", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h60, 3'd0);

        @(negedge clk);
        i_wr = 1'b0;
        i_rd = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, show-ahead (first-word-fall-through) FIFO with occupancy count and status flags. It is a generic buffering primitive placed between producer/consumer logic in the same clock domain. It reports overflow/underflow combinationally on the offending access cycle, so callers can detect lost writes or garbage reads.

Parameters:
ADDR_WIDTH, 3, pointer width; capacity DEPTH = 2^ADDR_WIDTH - 1 entries (one slot reserved so count fits ADDR_WIDTH bits).
DATA_WIDTH, 8, data word width in bits.

Ports:
i_clk  in  1  clock; all state updates on rising edge.
i_rst  in  1  reset; synchronous, active-low (0 = reset).
i_data  in  DATA_WIDTH  write data, captured when write accepted.
o_data  out  DATA_WIDTH  head-of-queue word, valid combinationally whenever !o_empty.
i_wr  in  1  write request, one word per cycle.
i_rd  in  1  read request (pop), one word per cycle.
o_count  out  ADDR_WIDTH  number of stored words, 0..DEPTH.
o_empty  out  1  count == 0.
o_full  out  1  count == DEPTH.
o_half_full  out  1  count >= 2^(ADDR_WIDTH-1).
o_overflow  out  1  combinational: current write will be dropped.
o_underflow  out  1  combinational: current read is on empty FIFO.

Behaviour:
- Storage: array of 2^ADDR_WIDTH words, write pointer, read pointer (ADDR_WIDTH bits, natural wrap-around), registered count. Asynchronous read of mem[rd_ptr] drives o_data.
- Reset (i_rst==0 at clock edge): wr_ptr=0, rd_ptr=0, count=0; memory contents not cleared. Reset has priority over i_wr/i_rd. After reset: o_empty=1, o_full=0, o_half_full=0, o_count=0. While i_rst==0, o_overflow=o_underflow=0.
- Flags are derived combinationally from registered count; they change on the edge after the access.
- Write accepted when i_wr && (!full || i_rd): mem[wr_ptr]<=i_data, wr_ptr+1.
- Read accepted when i_rd && !empty: rd_ptr+1. o_data in the cycle of i_rd is the word being popped (show-ahead, zero latency).
- o_overflow = i_wr && full && !i_rd. Write dropped, no state change from it.
- o_underflow = i_rd && empty. Read ignored; o_data is don't-care.
- Simultaneous i_wr && i_rd:
  - not empty, not full: both succeed, count unchanged.
  - full: read frees slot, write succeeds, no overflow, count stays DEPTH.
  - empty: underflow asserted, read ignored, write succeeds (no bypass); count becomes 1.
- Count: +1 on write-only accept, -1 on read-only accept, unchanged otherwise. Never exceeds DEPTH or goes below 0.
- Data order strictly FIFO across pointer wrap.

Test Plan:
- Reset: hold i_rst=0 5 cycles, release -> count=0, empty=1, full=0, half_full=0, overflow/underflow=0.
- Write 0x01..0x05 (5 cycles) -> count 1..5, half_full rises at count=4; then read 5 cycles -> o_data 0x01..0x05 in order, empty rises after last pop.
- Fill: write 10 consecutive words on empty FIFO -> first 7 accepted, full at count=7, writes 8-10 assert o_overflow and are lost.
- Drain: read 10 cycles -> 7 words in write order, then 3 cycles with o_underflow=1, count stays 0.
- Simultaneous rd+wr on empty for 10 cycles -> first cycle underflow, later cycles pass data with 1-cycle delay, count stays 1; then wr only 6 cycles -> full (7), no overflow.
- Full with rd+wr 10 cycles -> no overflow, count stays 7, order preserved across pointer wrap; stop wr, read 7 -> drains to empty; reset asserted mid-operation -> count returns to 0 next edge.
